ifetch_unit: RTL and testbench
==============================

IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h8000_0000, the first fetch address after reset.
REQ-002 SHALL have parameter QDEPTH, default 2, the depth of the instruction queue feeding decode (power of two, >=2).
REQ-003 clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 reset  in  1  reset, asynchronous assert, active-low (0 = reset).
REQ-005 ireq_valid  out  1  fetch request valid.
REQ-006 ireq_addr  out  64  fetch address.
REQ-007 iresp_addr_ok  in  1  bus accepted the request this cycle.
REQ-008 iresp_data_ok  in  1  bus returns instruction data this cycle.
REQ-009 iresp_data  in  32  returned raw instruction.
REQ-010 redirect_valid  in  1  flush and refetch (branch, jump, trap, mret).
REQ-011 redirect_pc  in  64  new fetch PC.
REQ-012 out_valid  out  1  queue head valid to decoder.
REQ-013 out_ready  in  1  decoder accepts head.
REQ-014 out_instr  out  32  raw_instr for decoder.
REQ-015 out_pc  out  64  PC of out_instr.
REQ-016 out_misalign  out  1  head carries instruction-address-misaligned exception.

Function
REQ-017 SHALL hold at most one outstanding bus request.
REQ-018 SHALL implement states IDLE, REQ, WAIT, DROP, HALT.
REQ-019 IDLE -> REQ when queue count + 0 outstanding < QDEPTH and pc[1:0]==0; IDLE -> HALT after pushing a misaligned entry when pc[1:0]!=0.
REQ-020 In REQ: ireq_valid=1, ireq_addr=pc, both held stable until iresp_addr_ok; on addr_ok pc<=pc+4 (64-bit wrap), go WAIT.
REQ-021 In WAIT: on iresp_data_ok push {iresp_data, request PC, misalign=0} into queue, go IDLE.
REQ-022 Misaligned fetch: no bus request; push {instr=32'h0000_0013, pc, misalign=1}; stay HALT until redirect.
REQ-023 Queue push on data_ok is registered: data_ok in cycle N -> out_valid at N+1 at earliest.
REQ-024 Pop when out_valid && out_ready; push and pop in the same cycle SHALL both occur; count never exceeds QDEPTH.
REQ-025 out_instr/out_pc/out_misalign SHALL remain stable while out_valid && !out_ready.
REQ-026 redirect_valid in cycle T: queue emptied at T+1 (out_valid=0), pc<=redirect_pc; redirect has priority over any same-cycle push/pop.
REQ-027 Redirect in IDLE or HALT -> IDLE; new request at T+1 if pc aligned.
REQ-028 Redirect in REQ without addr_ok -> request kept asserted with old address until addr_ok, then DROP; with addr_ok same cycle -> DROP.
REQ-029 Redirect in WAIT without data_ok -> DROP; with data_ok same cycle -> data discarded, go IDLE.
REQ-030 DROP: discard next data_ok without pushing, then IDLE; further redirects in DROP only update pc.
REQ-031 ireq_valid SHALL never be asserted in WAIT, DROP or HALT.

Reset
REQ-032 While reset=0: state=IDLE, pc=RESET_PC, queue empty, ireq_valid=0, out_valid=0, out_misalign=0, out_instr=0, out_pc=0.
REQ-033 Reset asserted mid-transaction SHALL abandon it; bus responses for the abandoned request after reset release are not expected by the bench.
REQ-034 First ireq_valid=1, ireq_addr=RESET_PC in the first cycle after reset release.

Verification
REQ-035 Reset release, addr_ok immediate, data_ok 1 cycle later with 32'h0010_0093 -> out_valid next cycle, out_instr=32'h0010_0093, out_pc=64'h8000_0000; next ireq_addr=64'h8000_0004.
REQ-036 out_ready=0 for 10 cycles with QDEPTH=2 -> exactly two entries (PCs ...0000, ...0004), ireq_valid=0 afterwards, head stable.
REQ-037 Redirect to 64'h8000_0100 while in WAIT -> next data_ok dropped (no out_valid), following ireq_addr=64'h8000_0100.
REQ-038 Redirect with addr_ok withheld 3 cycles -> ireq_addr unchanged until addr_ok, response dropped, then request to redirect_pc.
REQ-039 Redirect to 64'h8000_0102 -> no bus request, out_valid with out_misalign=1, out_pc=64'h8000_0102, out_instr=32'h0000_0013; no further fetch until next redirect.
REQ-040 Redirect coincident with data_ok and out_ready -> queue empty next cycle, data not delivered.

Source files
------------

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: keeps one bus request in flight and buffers the returned
// instructions in a small queue for decode, with redirect flush and misaligned-PC trap.
module ifetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h8000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        ireq_valid,
    output logic [63:0] ireq_addr,
    input  logic        iresp_addr_ok,
    input  logic        iresp_data_ok,
    input  logic [31:0] iresp_data,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [63:0] out_pc,
    output logic        out_misalign
);

    // state | meaning
    // IDLE  | no request in flight; issue when queue has room, trap if pc misaligned
    // REQ   | request on the bus, waiting for addr_ok
    // WAIT  | request accepted, waiting for data_ok to push into queue
    // DROP  | accepted request was overtaken by a redirect; swallow its data
    // HALT  | misaligned entry queued; wait for a redirect
    typedef enum logic [2:0] {IDLE, REQ, WAIT, DROP, HALT} state_t;

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;

    state_t      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [63:0] req_pc_q, req_pc_d;
    logic        killed_q, killed_d;

    logic        push, pop, has_room;
    logic [31:0] push_instr;
    logic [63:0] push_pc;
    logic        push_mis;

    logic [31:0] instr_q [QDEPTH];
    logic [63:0] pcs_q   [QDEPTH];
    logic        mis_q   [QDEPTH];
    logic [PW-1:0] wr_q, rd_q;
    logic [CW-1:0] cnt_q;

    assign has_room     = cnt_q < CW'(QDEPTH);
    assign out_valid    = cnt_q != '0;
    assign out_instr    = instr_q[rd_q];
    assign out_pc       = pcs_q[rd_q];
    assign out_misalign = mis_q[rd_q];
    assign pop          = out_valid && out_ready && !redirect_valid;
    assign ireq_valid   = state_q == REQ;
    assign ireq_addr    = req_pc_q;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        killed_d   = killed_q;
        push       = 1'b0;
        push_instr = iresp_data;
        push_pc    = req_pc_q;
        push_mis   = 1'b0;
        case (state_q)
            IDLE, HALT: begin
                if (redirect_valid) begin
                    // queue is flushed by the redirect, so an aligned target can issue at once
                    pc_d = redirect_pc;
                    if (redirect_pc[1:0] == 2'b00) begin
                        state_d  = REQ;
                        req_pc_d = redirect_pc;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (state_q == IDLE && has_room) begin
                    if (pc_q[1:0] == 2'b00) begin
                        state_d  = REQ;
                        req_pc_d = pc_q;
                    end else begin
                        push       = 1'b1;
                        push_instr = 32'h0000_0013;
                        push_pc    = pc_q;
                        push_mis   = 1'b1;
                        state_d    = HALT;
                    end
                end
            end
            REQ: begin
                // a redirect cannot retract a posted request; remember it and drop the data later
                if (redirect_valid) pc_d = redirect_pc;
                if (iresp_addr_ok) begin
                    killed_d = 1'b0;
                    if (redirect_valid || killed_q) begin
                        state_d = DROP;
                    end else begin
                        state_d = WAIT;
                        pc_d    = pc_q + 64'd4;
                    end
                end else if (redirect_valid) begin
                    killed_d = 1'b1;
                end
            end
            WAIT: begin
                if (redirect_valid) begin
                    pc_d    = redirect_pc;
                    state_d = iresp_data_ok ? IDLE : DROP;
                end else if (iresp_data_ok) begin
                    push    = 1'b1;
                    state_d = IDLE;
                end
            end
            DROP: begin
                if (redirect_valid) pc_d = redirect_pc;
                if (iresp_data_ok) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            req_pc_q <= RESET_PC;
            killed_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            killed_q <= killed_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                instr_q[i] <= '0;
                pcs_q[i]   <= '0;
                mis_q[i]   <= 1'b0;
            end
        end else if (redirect_valid) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) begin
                instr_q[wr_q] <= push_instr;
                pcs_q[wr_q]   <= push_pc;
                mis_q[wr_q]   <= push_mis;
                wr_q          <= wr_q + PW'(1);
            end
            if (pop) rd_q <= rd_q + PW'(1);
            cnt_q <= cnt_q + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: directed scenarios then random bus/decoder/redirect traffic,
// all checked against a transaction-level model of fetch order and queue contents.
module tb_ifetch_unit;

    localparam logic [63:0] RESET_PC = 64'h8000_0000;
    localparam int          QDEPTH   = 2;

    logic        clk;
    logic        reset;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        iresp_addr_ok;
    logic        iresp_data_ok;
    logic [31:0] iresp_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
    logic        out_misalign;

    ifetch_unit #(.RESET_PC(RESET_PC), .QDEPTH(QDEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .ireq_valid     (ireq_valid),
        .ireq_addr      (ireq_addr),
        .iresp_addr_ok  (iresp_addr_ok),
        .iresp_data_ok  (iresp_data_ok),
        .iresp_data     (iresp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_misalign   (out_misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] instr;
        logic [63:0] pc;
        logic        mis;
    } ent_t;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    ent_t        mq[$];
    logic [63:0] m_pc;
    logic        pend, pend_doom, outst, out_doom, mis_exp;
    logic [63:0] pend_addr, out_addr;
    int          mis_cnt;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pc      = RESET_PC;
        pend      = 1'b0;
        pend_doom = 1'b0;
        outst     = 1'b0;
        out_doom  = 1'b0;
        mis_exp   = 1'b0;
        pend_addr = '0;
        out_addr  = '0;
        mis_cnt   = 0;
    endtask

    // Called at a falling edge: check visible outputs, drive inputs, advance model one cycle.
    task automatic step(input logic aok, input logic dok, input logic [31:0] dat,
                        input logic rdy, input logic rv, input logic [63:0] rpc);
        logic dok_e;
        ent_t e;
        if (mis_exp && mq.size() == 0 && out_valid) begin
            e.instr = 32'h0000_0013;
            e.pc    = m_pc;
            e.mis   = 1'b1;
            mq.push_back(e);
            mis_exp = 1'b0;
        end
        if (mq.size() != 0) begin
            check_val("out_valid", 64'(out_valid), 64'd1);
            check_val("out_instr", 64'(out_instr), 64'(mq[0].instr));
            check_val("out_pc", out_pc, mq[0].pc);
            check_val("out_misalign", 64'(out_misalign), 64'(mq[0].mis));
        end else begin
            check_val("out_empty", 64'(out_valid), 64'd0);
        end
        if (mis_exp && !pend && !outst && !out_valid) begin
            mis_cnt++;
            if (mis_cnt > 4) begin
                check_val("mis_timeout", 64'(out_valid), 64'd1);
                mis_exp = 1'b0;
            end
        end
        if (ireq_valid) begin
            if (!pend) begin
                check_val("req_addr", ireq_addr, m_pc);
                check_val("req_allowed", {61'd0, outst, mq.size() >= QDEPTH, m_pc[1:0] != 2'b00}, 64'd0);
                pend      = 1'b1;
                pend_addr = ireq_addr;
                pend_doom = 1'b0;
            end else begin
                check_val("req_hold", ireq_addr, pend_addr);
            end
        end else if (pend) begin
            check_val("req_kept_valid", 64'(ireq_valid), 64'd1);
            pend = 1'b0;
        end

        dok_e          = dok && outst;
        iresp_addr_ok  = aok;
        iresp_data_ok  = dok_e;
        iresp_data     = dat;
        out_ready      = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;

        if (out_valid && rdy && !rv && mq.size() != 0) void'(mq.pop_front());
        if (dok_e) begin
            if (!out_doom && !rv) begin
                check_val("no_overflow", 64'(mq.size() < QDEPTH), 64'd1);
                e.instr = dat;
                e.pc    = out_addr;
                e.mis   = 1'b0;
                mq.push_back(e);
            end
            outst = 1'b0;
        end
        if (pend && aok) begin
            outst    = 1'b1;
            out_addr = pend_addr;
            out_doom = pend_doom || rv;
            if (!out_doom) m_pc = m_pc + 64'd4;
            pend = 1'b0;
        end
        if (rv) begin
            mq.delete();
            m_pc = rpc;
            if (pend) pend_doom = 1'b1;
            if (outst) out_doom = 1'b1;
            mis_exp = rpc[1:0] != 2'b00;
            mis_cnt = 0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_reset_outputs();
        check_val("rst_ireq_valid", 64'(ireq_valid), 64'd0);
        check_val("rst_out_valid", 64'(out_valid), 64'd0);
        check_val("rst_out_misalign", 64'(out_misalign), 64'd0);
        check_val("rst_out_instr", 64'(out_instr), 64'd0);
        check_val("rst_out_pc", out_pc, 64'd0);
    endtask

    function automatic logic [63:0] rand_target();
        logic [63:0] t;
        int r;
        r = $urandom_range(0, 11);
        t = 64'h8000_0000 + 64'($urandom_range(0, 1023)) * 64'd4;
        if (r == 0) t = 64'hFFFF_FFFF_FFFF_FFF8;
        else if (r <= 2) t = t | 64'($urandom_range(1, 3));
        return t;
    endfunction

    initial begin
        reset          = 1'b0;
        iresp_addr_ok  = 1'b0;
        iresp_data_ok  = 1'b0;
        iresp_data     = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_outputs();
        reset = 1'b1;

        // first fetch after reset and single-instruction latency
        step(0, 0, 0, 0, 0, 0);
        check_val("first_req_valid", 64'(ireq_valid), 64'd1);
        check_val("first_req_addr", ireq_addr, RESET_PC);
        step(1, 0, 0, 0, 0, 0);
        check_val("wait_no_req", 64'(ireq_valid), 64'd0);
        check_val("no_early_out", 64'(out_valid), 64'd0);
        step(0, 1, 32'h0010_0093, 0, 0, 0);
        check_val("first_out_valid", 64'(out_valid), 64'd1);
        check_val("first_out_instr", 64'(out_instr), 64'h0010_0093);
        check_val("first_out_pc", out_pc, 64'h8000_0000);
        step(0, 0, 0, 0, 0, 0);
        check_val("second_req_addr", ireq_addr, 64'h8000_0004);

        // decoder stalled: queue fills to QDEPTH and fetch stops
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 32'h0020_0113, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 0, 0, 0, 0);
            check_val("full_no_req", 64'(ireq_valid), 64'd0);
            check_val("full_head_pc", out_pc, 64'h8000_0000);
        end
        step(0, 0, 0, 1, 0, 0);
        check_val("second_entry_pc", out_pc, 64'h8000_0004);
        step(0, 0, 0, 1, 0, 0);
        check_val("drained", 64'(out_valid), 64'd0);

        // redirect while waiting for data
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 64'h8000_0100);
        step(0, 1, 32'hDEAD_BEEF, 0, 0, 0);
        check_val("wait_redir_dropped", 64'(out_valid), 64'd0);
        step(0, 0, 0, 0, 0, 0);
        check_val("wait_redir_req", ireq_addr, 64'h8000_0100);

        // redirect with addr_ok withheld
        step(0, 0, 0, 0, 1, 64'h8000_0200);
        check_val("hold_addr_1", ireq_addr, 64'h8000_0100);
        step(0, 0, 0, 0, 0, 0);
        check_val("hold_addr_2", ireq_addr, 64'h8000_0100);
        step(0, 0, 0, 0, 0, 0);
        check_val("hold_addr_3", ireq_addr, 64'h8000_0100);
        check_val("hold_valid", 64'(ireq_valid), 64'd1);
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 32'h1234_5678, 0, 0, 0);
        check_val("req_redir_dropped", 64'(out_valid), 64'd0);
        step(0, 0, 0, 0, 0, 0);
        check_val("req_redir_req", ireq_addr, 64'h8000_0200);

        // redirect coincident with data_ok and out_ready
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 32'h0000_1111, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 32'h0000_2222, 1, 1, 64'h8000_0300);
        check_val("coinc_flushed", 64'(out_valid), 64'd0);
        step(0, 0, 0, 0, 0, 0);
        check_val("coinc_req", ireq_addr, 64'h8000_0300);

        // misaligned redirect
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 32'h0000_3333, 1, 0, 0);
        step(0, 0, 0, 1, 1, 64'h8000_0102);
        check_val("mis_no_req", 64'(ireq_valid), 64'd0);
        step(0, 0, 0, 0, 0, 0);
        check_val("mis_valid", 64'(out_valid), 64'd1);
        check_val("mis_flag", 64'(out_misalign), 64'd1);
        check_val("mis_pc", out_pc, 64'h8000_0102);
        check_val("mis_instr", 64'(out_instr), 64'h0000_0013);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 1, 0, 0);
            check_val("halt_no_req", 64'(ireq_valid), 64'd0);
        end
        step(0, 0, 0, 0, 1, 64'h8000_0400);
        check_val("halt_exit_valid", 64'(ireq_valid), 64'd1);
        check_val("halt_exit_addr", ireq_addr, 64'h8000_0400);

        // reset in the middle of a transaction
        step(1, 0, 0, 0, 0, 0);
        reset          = 1'b0;
        iresp_addr_ok  = 1'b0;
        iresp_data_ok  = 1'b0;
        redirect_valid = 1'b0;
        out_ready      = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_outputs();
        reset = 1'b1;

        for (int i = 0; i < 3000; i++) begin
            logic rv;
            rv = $urandom_range(0, 24) == 0;
            step($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom,
                 $urandom_range(0, 9) < 7, rv, rv ? rand_target() : 64'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
